// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
//   state_e      : arbiter FSM states (idle, memory access in flight, response pulse)
//   owner_e      : which requester currently owns the memory port
//   MEM_ERR_DATA : read data returned when main memory never acknowledges
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMem  = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  localparam logic [31:0] MEM_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of all arbiter-facing signals: instruction-cache refill port, data-side port and the
// shared main-memory port.
//   slave  : view taken by the arbiter (consumes requests and memory responses)
//   master : view taken by the environment (requesters and main memory)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // Instruction side
  logic                  ic_req_i;
  logic [ADDR_WIDTH-1:0] ic_addr_i;
  logic [DATA_WIDTH-1:0] ic_rdata_o;
  logic                  ic_done_o;
  // Data side
  logic                  dc_req_i;
  logic                  dc_we_i;
  logic [ADDR_WIDTH-1:0] dc_addr_i;
  logic [DATA_WIDTH-1:0] dc_wdata_i;
  logic [DATA_WIDTH-1:0] dc_rdata_o;
  logic                  dc_done_o;
  // Main memory
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ack_i;
  // Status
  logic                  err_o;
  logic                  busy_o;

  modport slave (
    input  ic_req_i, ic_addr_i,
    output ic_rdata_o, ic_done_o,
    input  dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
    output dc_rdata_o, dc_done_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i,
    output err_o, busy_o
  );

  modport master (
    output ic_req_i, ic_addr_i,
    input  ic_rdata_o, ic_done_o,
    output dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
    input  dc_rdata_o, dc_done_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i,
    input  err_o, busy_o
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin selector.
//   req_i : {dc, ic} request pair
//   ptr_i : side that wins when both request
//   gnt_o : one-hot grant {dc, ic}; zero when nobody requests
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b00: gnt_o = 2'b00;
      2'b01: gnt_o = 2'b01;
      2'b10: gnt_o = 2'b10;
      2'b11: gnt_o = (ptr_i == OWN_IC) ? 2'b01 : 2'b10;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single main-memory port between an instruction-cache refill port and a data
// port. One transaction at a time: IDLE grants, MEM holds the memory request until ack (or
// timeout), RESP pulses the owner's done for one cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave view of mem_port_arbiter_if (requester ports, memory port, err/busy)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned           CntWidth = $clog2(TIMEOUT_CYCLES + 1);
  // cnt_q holds the number of MEM cycles already elapsed, so the last allowed cycle is N-1.
  localparam logic [CntWidth-1:0]   CntLast  = CntWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] ErrData  = DATA_WIDTH'(MEM_ERR_DATA);

  state_e                state_q;
  owner_e                owner_q;
  owner_e                ptr_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] ic_rdata_q;
  logic [DATA_WIDTH-1:0] dc_rdata_q;
  logic                  ic_done_q;
  logic                  dc_done_q;
  logic                  err_q;

  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  finish;
  logic [DATA_WIDTH-1:0] rdata_next;

  assign req = {bus.dc_req_i, bus.ic_req_i};

  rr_arb2 u_rr_arb2 (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  // Ack wins over a timeout landing in the same cycle.
  assign finish     = bus.mem_ack_i || (cnt_q == CntLast);
  assign rdata_next = bus.mem_ack_i ? bus.mem_rdata_i : ErrData;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= OWN_IC;
      ptr_q       <= OWN_IC;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      ic_done_q   <= 1'b0;
      dc_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q   <= StMem;
            mem_req_q <= 1'b1;
            cnt_q     <= '0;
            // Pointer flips on every grant, contested or not.
            ptr_q     <= (ptr_q == OWN_IC) ? OWN_DC : OWN_IC;
            if (gnt[0]) begin
              owner_q     <= OWN_IC;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= bus.ic_addr_i;
              mem_wdata_q <= '0;
            end else begin
              owner_q     <= OWN_DC;
              mem_we_q    <= bus.dc_we_i;
              mem_addr_q  <= bus.dc_addr_i;
              mem_wdata_q <= bus.dc_wdata_i;
            end
          end
        end
        StMem: begin
          if (finish) begin
            state_q   <= StResp;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= !bus.mem_ack_i;
            if (owner_q == OWN_IC) begin
              ic_done_q  <= 1'b1;
              ic_rdata_q <= rdata_next;
            end else begin
              dc_done_q <= 1'b1;
              if (!mem_we_q) begin
                dc_rdata_q <= rdata_next;
              end
            end
          end else begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.ic_rdata_o  = ic_rdata_q;
  assign bus.dc_rdata_o  = dc_rdata_q;
  assign bus.ic_done_o   = ic_done_q;
  assign bus.dc_done_o   = dc_done_q;
  assign bus.err_o       = err_q;
  assign bus.busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (pending requests, round-robin pointer, rdata per side).
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, still running");
    $fatal(1, "watchdog");
  end

  // Outputs are registered, so 1 time unit after the edge they are stable for the cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.ic_req_i    = 1'b0;
    bus.ic_addr_i   = '0;
    bus.dc_req_i    = 1'b0;
    bus.dc_we_i     = 1'b0;
    bus.dc_addr_i   = '0;
    bus.dc_wdata_i  = '0;
    bus.mem_rdata_i = '0;
    bus.mem_ack_i   = 1'b0;
  endtask

  // Leaves the bench just after a clock edge with reset released and the arbiter idle.
  task automatic do_reset();
    drive_idle();
    #2 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({bus.mem_req_o, bus.mem_we_o} !== 2'b00 || bus.mem_addr_o !== '0 ||
        bus.mem_wdata_o !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h, required all zero",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    n_tests++;
    if ({bus.ic_done_o, bus.dc_done_o, bus.err_o, bus.busy_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_status: ic_done,dc_done,err,busy=%b, required 0000",
               {bus.ic_done_o, bus.dc_done_o, bus.err_o, bus.busy_o});
    end
    n_tests++;
    if (bus.ic_rdata_o !== '0 || bus.dc_rdata_o !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: ic=%h dc=%h, required 0", bus.ic_rdata_o, bus.dc_rdata_o);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.busy_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: busy=%b mem_req=%b, required 0 0", bus.busy_o, bus.mem_req_o);
    end
  endtask

  task automatic test_ic_read();
    int done_cnt = 0;
    bit we_seen  = 1'b0;
    do_reset();
    bus.ic_req_i  = 1'b1;
    bus.ic_addr_i = 32'h0000_0100;
    tick();
    n_tests++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL ic_read_issue: mem_req=%b addr=%h, required 1 00000100",
               bus.mem_req_o, bus.mem_addr_o);
    end
    for (int k = 0; k < 3; k++) begin
      if (bus.mem_we_o !== 1'b0) we_seen = 1'b1;
      if (bus.ic_done_o === 1'b1) done_cnt++;
      tick();
    end
    if (bus.mem_we_o !== 1'b0) we_seen = 1'b1;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h0FF0_0313;
    tick();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    bus.ic_req_i    = 1'b0;
    n_tests++;
    if (bus.ic_done_o !== 1'b1 || bus.ic_rdata_o !== 32'h0FF0_0313 || bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ic_read_done: done=%b rdata=%h err=%b, required 1 0ff00313 0",
               bus.ic_done_o, bus.ic_rdata_o, bus.err_o);
    end
    for (int k = 0; k < 5; k++) begin
      if (bus.mem_we_o !== 1'b0) we_seen = 1'b1;
      if (bus.ic_done_o === 1'b1) done_cnt++;
      tick();
    end
    n_tests++;
    if (done_cnt != 1 || we_seen) begin
      n_fail++;
      $display("FAIL ic_read_pulse: done pulses=%0d we_seen=%b, required 1 0", done_cnt, we_seen);
    end
    n_tests++;
    if (bus.ic_rdata_o !== 32'h0FF0_0313) begin
      n_fail++;
      $display("FAIL ic_read_hold: rdata=%h, required 0ff00313", bus.ic_rdata_o);
    end
  endtask

  task automatic test_contention();
    do_reset();
    bus.ic_req_i   = 1'b1;
    bus.ic_addr_i  = 32'h0000_0300;
    bus.dc_req_i   = 1'b1;
    bus.dc_we_i    = 1'b1;
    bus.dc_addr_i  = 32'h0000_2000;
    bus.dc_wdata_i = 32'h1234_5678;
    tick();
    n_tests++;
    if (bus.mem_addr_o !== 32'h0000_0300 || bus.mem_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL contend_first_ic: addr=%h we=%b, required 00000300 0",
               bus.mem_addr_o, bus.mem_we_o);
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hAAAA_5555;
    tick();
    bus.mem_ack_i = 1'b0;
    bus.ic_req_i  = 1'b0;
    n_tests++;
    if (bus.ic_done_o !== 1'b1 || bus.dc_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL contend_ic_done: ic_done=%b dc_done=%b, required 1 0",
               bus.ic_done_o, bus.dc_done_o);
    end
    tick();
    tick();
    n_tests++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_2000 ||
        bus.mem_wdata_o !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL contend_dc_write: req=%b we=%b addr=%h wdata=%h, required 1 1 2000 12345678",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h5A5A_5A5A;
    tick();
    bus.mem_ack_i = 1'b0;
    n_tests++;
    if (bus.dc_done_o !== 1'b1 || bus.dc_rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL contend_dc_done: dc_done=%b dc_rdata=%h, required 1 00000000",
               bus.dc_done_o, bus.dc_rdata_o);
    end
    // Fresh contested request: pointer must be back on the instruction side.
    bus.ic_req_i  = 1'b1;
    bus.ic_addr_i = 32'h0000_0304;
    bus.dc_we_i   = 1'b0;
    bus.dc_addr_i = 32'h0000_2004;
    tick();
    tick();
    n_tests++;
    if (bus.mem_addr_o !== 32'h0000_0304) begin
      n_fail++;
      $display("FAIL contend_ptr_back: addr=%h, required 00000304", bus.mem_addr_o);
    end
  endtask

  task automatic test_alternate();
    logic [31:0] exp_addr;
    do_reset();
    bus.ic_req_i  = 1'b1;
    bus.ic_addr_i = 32'h0000_0040;
    bus.dc_req_i  = 1'b1;
    bus.dc_we_i   = 1'b0;
    bus.dc_addr_i = 32'h0000_0080;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_addr = (i % 2 == 0) ? 32'h0000_0040 : 32'h0000_0080;
      n_tests++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== exp_addr) begin
        n_fail++;
        $display("FAIL alternate_grant%0d: req=%b addr=%h, required 1 %h",
                 i, bus.mem_req_o, bus.mem_addr_o, exp_addr);
      end
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'(i + 1);
      tick();
      bus.mem_ack_i = 1'b0;
      n_tests++;
      if ({bus.ic_done_o, bus.dc_done_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL alternate_done%0d: ic_done,dc_done=%b, required %b",
                 i, {bus.ic_done_o, bus.dc_done_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    do_reset();
    bus.dc_req_i  = 1'b1;
    bus.dc_we_i   = 1'b0;
    bus.dc_addr_i = 32'h0000_0044;
    tick();
    for (int k = 1; k <= int'(TO); k++) begin
      if (bus.mem_req_o !== 1'b1 || bus.dc_done_o !== 1'b0 || bus.err_o !== 1'b0) early = 1'b1;
      tick();
    end
    n_tests++;
    if (early) begin
      n_fail++;
      $display("FAIL timeout_early: request ended before %0d MEM cycles, required full wait", TO);
    end
    n_tests++;
    if (bus.dc_done_o !== 1'b1 || bus.err_o !== 1'b1 || bus.mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_done: dc_done=%b err=%b mem_req=%b, required 1 1 0",
               bus.dc_done_o, bus.err_o, bus.mem_req_o);
    end
    n_tests++;
    if (bus.dc_rdata_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL timeout_rdata: dc_rdata=%h, required deadbeef", bus.dc_rdata_o);
    end
    bus.dc_req_i = 1'b0;
    tick();
    n_tests++;
    if (bus.err_o !== 1'b0 || bus.dc_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: err=%b dc_done=%b one cycle later, required 0 0",
               bus.err_o, bus.dc_done_o);
    end
  endtask

  task automatic test_ack_at_limit();
    bit early = 1'b0;
    do_reset();
    bus.dc_req_i  = 1'b1;
    bus.dc_we_i   = 1'b0;
    bus.dc_addr_i = 32'h0000_0048;
    tick();
    for (int k = 1; k < int'(TO); k++) tick();
    if (bus.mem_req_o !== 1'b1 || bus.dc_done_o !== 1'b0) early = 1'b1;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hCAFE_F00D;
    tick();
    bus.mem_ack_i = 1'b0;
    n_tests++;
    if (early || bus.dc_done_o !== 1'b1 || bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_limit_done: early=%b dc_done=%b err=%b, required 0 1 0",
               early, bus.dc_done_o, bus.err_o);
    end
    n_tests++;
    if (bus.dc_rdata_o !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL ack_limit_rdata: dc_rdata=%h, required cafef00d", bus.dc_rdata_o);
    end
  endtask

  // Starts in the response cycle left by test_ack_at_limit, so dc_rdata is non-zero.
  task automatic test_reset_mid_mem();
    int done_cnt = 0;
    bus.dc_req_i = 1'b0;
    tick();
    bus.ic_req_i  = 1'b1;
    bus.ic_addr_i = 32'h0000_0500;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.mem_req_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: mem_req=%b busy=%b right after reset, required 0 0",
               bus.mem_req_o, bus.busy_o);
    end
    n_tests++;
    if (bus.dc_rdata_o !== '0 || bus.ic_rdata_o !== '0) begin
      n_fail++;
      $display("FAIL midreset_rdata: ic=%h dc=%h, required 0", bus.ic_rdata_o, bus.dc_rdata_o);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      if (bus.ic_done_o === 1'b1 || bus.dc_done_o === 1'b1) done_cnt++;
    end
    rst_n = 1'b1;
    tick();
    if (bus.ic_done_o === 1'b1 || bus.dc_done_o === 1'b1) done_cnt++;
    n_tests++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_0500) begin
      n_fail++;
      $display("FAIL midreset_rereq: mem_req=%b addr=%h, required 1 00000500",
               bus.mem_req_o, bus.mem_addr_o);
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h1122_3344;
    tick();
    bus.mem_ack_i = 1'b0;
    bus.ic_req_i  = 1'b0;
    n_tests++;
    if (bus.ic_done_o !== 1'b1 || bus.ic_rdata_o !== 32'h1122_3344 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL midreset_complete: done=%b rdata=%h stray pulses=%0d, required 1 11223344 0",
               bus.ic_done_o, bus.ic_rdata_o, done_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    bit          pend_ic = 1'b0;
    bit          pend_dc = 1'b0;
    bit          ptr_dc  = 1'b0;
    bit          win_dc;
    logic        dc_we   = 1'b0;
    logic [31:0] ic_addr = '0;
    logic [31:0] dc_addr = '0;
    logic [31:0] dc_wdata = '0;
    logic [31:0] exp_ic  = '0;
    logic [31:0] exp_dc  = '0;
    logic [31:0] exp_addr;
    logic [31:0] rd;
    logic        exp_we;
    int          d;
    bit          bad;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      // Idle cycle: top up pending requests; unrelated acks here must be ignored.
      if (!pend_ic && $urandom_range(0, 1) == 1) begin
        pend_ic = 1'b1;
        ic_addr = $urandom;
      end
      if (!pend_dc && $urandom_range(0, 1) == 1) begin
        pend_dc  = 1'b1;
        dc_we    = 1'($urandom_range(0, 1));
        dc_addr  = $urandom;
        dc_wdata = $urandom;
      end
      if (!pend_ic && !pend_dc) begin
        pend_ic = 1'b1;
        ic_addr = $urandom;
      end
      bus.ic_req_i    = pend_ic;
      bus.ic_addr_i   = ic_addr;
      bus.dc_req_i    = pend_dc;
      bus.dc_we_i     = dc_we;
      bus.dc_addr_i   = dc_addr;
      bus.dc_wdata_i  = dc_wdata;
      bus.mem_ack_i   = 1'($urandom_range(0, 1));
      bus.mem_rdata_i = $urandom;
      n_tests++;
      if (bus.busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_idle: busy=%b, required 0", it, bus.busy_o);
      end
      win_dc   = pend_dc && (!pend_ic || ptr_dc);
      ptr_dc   = !ptr_dc;
      exp_we   = win_dc ? dc_we : 1'b0;
      exp_addr = win_dc ? dc_addr : ic_addr;
      tick();
      n_tests++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== exp_we || bus.mem_addr_o !== exp_addr ||
          (exp_we && bus.mem_wdata_o !== dc_wdata)) begin
        n_fail++;
        $display("FAIL rand%0d_issue: req=%b we=%b addr=%h wdata=%h, required 1 %b %h %h",
                 it, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o,
                 exp_we, exp_addr, exp_we ? dc_wdata : bus.mem_wdata_o);
      end
      bus.mem_ack_i = 1'b0;
      d   = int'($urandom_range(0, 4));
      bad = 1'b0;
      for (int k = 0; k < d; k++) begin
        tick();
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== exp_addr || bus.ic_done_o !== 1'b0 ||
            bus.dc_done_o !== 1'b0) bad = 1'b1;
      end
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL rand%0d_wait: request not held stable for %0d wait cycles", it, d);
      end
      rd = $urandom;
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = rd;
      tick();
      if (win_dc) begin
        if (!dc_we) exp_dc = rd;
        pend_dc = 1'b0;
      end else begin
        exp_ic  = rd;
        pend_ic = 1'b0;
      end
      n_tests++;
      if (bus.ic_done_o !== !win_dc || bus.dc_done_o !== win_dc || bus.err_o !== 1'b0 ||
          bus.mem_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_done: ic_done=%b dc_done=%b err=%b mem_req=%b, required %b %b 0 0",
                 it, bus.ic_done_o, bus.dc_done_o, bus.err_o, bus.mem_req_o, !win_dc, win_dc);
      end
      n_tests++;
      if (bus.ic_rdata_o !== exp_ic || bus.dc_rdata_o !== exp_dc) begin
        n_fail++;
        $display("FAIL rand%0d_rdata: ic=%h dc=%h, required %h %h",
                 it, bus.ic_rdata_o, bus.dc_rdata_o, exp_ic, exp_dc);
      end
      // Response cycle: drop the winner; stray acks here must be ignored too.
      bus.ic_req_i    = pend_ic;
      bus.dc_req_i    = pend_dc;
      bus.mem_ack_i   = 1'($urandom_range(0, 1));
      bus.mem_rdata_i = $urandom;
      tick();
      bus.mem_ack_i = 1'b0;
      n_tests++;
      if (bus.ic_done_o !== 1'b0 || bus.dc_done_o !== 1'b0 || bus.ic_rdata_o !== exp_ic ||
          bus.dc_rdata_o !== exp_dc) begin
        n_fail++;
        $display("FAIL rand%0d_after: ic_done=%b dc_done=%b ic=%h dc=%h, required 0 0 %h %h",
                 it, bus.ic_done_o, bus.dc_done_o, bus.ic_rdata_o, bus.dc_rdata_o,
                 exp_ic, exp_dc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_contention();
    test_alternate();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_mem();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 64, the maximum number of cycles to wait for mem_ack_i.
REQ-004 The block SHALL have the following ports; the clock is single, and the reset is asynchronous, active-low:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
ic_req_i  in  1  instruction-cache refill request (level)
ic_addr_i  in  ADDR_WIDTH  refill address
ic_rdata_o  out  DATA_WIDTH  refill word
ic_done_o  out  1  one-cycle completion pulse
dc_req_i  in  1  data-side request (level)
dc_we_i  in  1  1=write, 0=read
dc_addr_i  in  ADDR_WIDTH  data address
dc_wdata_i  in  DATA_WIDTH  write data
dc_rdata_o  out  DATA_WIDTH  read data
dc_done_o  out  1  one-cycle completion pulse
mem_req_o  out  1  main-memory request, held until ack
mem_we_o  out  1  main-memory write enable
mem_addr_o  out  ADDR_WIDTH  main-memory address
mem_wdata_o  out  DATA_WIDTH  main-memory write data
mem_rdata_i  in  DATA_WIDTH  main-memory read data, valid with ack
mem_ack_i  in  1  main-memory completion, one cycle
err_o  out  1  one-cycle timeout pulse, coincident with done
busy_o  out  1  high when the FSM is not in IDLE

Function
REQ-005 The FSM SHALL have three states: IDLE, MEM and RESP; busy_o SHALL be 1 in MEM and RESP.
REQ-006 In IDLE, if any request is high, the arbiter SHALL grant one requester, latch its address, write enable and write data, and go to MEM on the next edge; the instruction side always has write enable 0.
REQ-007 When both requests are high in the same IDLE cycle, the arbiter SHALL grant the side selected by a round-robin pointer; the pointer SHALL move to the other side after every grant, including uncontested grants.
REQ-008 In MEM, mem_req_o SHALL be 1 and mem_we_o, mem_addr_o and mem_wdata_o SHALL drive the latched values, stable until ack.
REQ-009 On mem_ack_i=1 in MEM, the block SHALL register mem_rdata_i (reads only) into the granted side's rdata register and go to RESP.
REQ-010 mem_ack_i seen outside MEM SHALL be ignored.
REQ-011 In RESP, the granted side's done pulse SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; requests SHALL NOT be sampled in RESP.
REQ-012 Minimum latency: request high in cycle N, mem_req_o=1 in N+1, ack in N+1, done in N+2.
REQ-013 A requester SHALL keep its request and operands stable until its done pulse; a request still high in the IDLE cycle after done SHALL be treated as a new transaction.
REQ-014 rdata_o registers SHALL hold their value until that side's next completion; a write completion SHALL leave dc_rdata_o unchanged.
REQ-015 A wait counter SHALL count cycles in MEM; if it reaches TIMEOUT_CYCLES without ack, the block SHALL go to RESP with rdata = 0xDEADBEEF (reads) and err_o=1 during that done cycle.
REQ-016 An ack arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL take precedence: normal completion, err_o=0.

Reset
REQ-017 Asserting rst_n=0 at any time, including mid-MEM, SHALL immediately force state=IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, ic_done_o=0, dc_done_o=0, err_o=0, busy_o=0, ic_rdata_o=0, dc_rdata_o=0, wait counter=0, and round-robin pointer=instruction side.
REQ-018 A transaction interrupted by reset SHALL be dropped with no done pulse; requesters re-request after reset.

Structure
REQ-019 The shared package SHALL hold the FSM state enum (IDLE/MEM/RESP), the owner enum (OWN_IC/OWN_DC) and the constant MEM_ERR_DATA=32'hDEADBEEF.
REQ-020 The 2-requester round-robin selector (request pair plus pointer in, one-hot grant out) SHALL be a sub-module named rr_arb2.

Verification
REQ-021 ic_req_i=1, addr 0x0000_0100, ack after 3 cycles with data 0x0FF00313 -> ic_done_o pulses once, ic_rdata_o=0x0FF00313, mem_we_o=0 throughout.
REQ-022 Both requests high after reset -> instruction side granted first; dc write (addr 0x2000, data 0x12345678) granted second with mem_we_o=1; pointer returns to instruction side.
REQ-023 Both requests held continuously -> grants alternate IC, DC, IC, DC, with no side starved.
REQ-024 No ack on a dc read -> after 64 cycles in MEM, dc_done_o=1 and err_o=1 together, dc_rdata_o=0xDEADBEEF.
REQ-025 rst_n=0 mid-MEM -> mem_req_o=0 in the same cycle, no done pulse; after release, the re-request completes normally.
REQ-026 Ack arriving on exactly cycle 64 -> normal data is returned, err_o=0.
